snn_config_loader: RTL

SNN_CONFIG_LOADER -- requirements
Module: snn_config_loader

---
 rtl/snn_config_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/snn_config_loader.sv
// Byte-serial configuration loader for the two-layer SNN: streams weights, delays and
// shared neuron parameters into output registers. Define SNN_CFG_CHECKSUM_EN to add a trailing checksum byte.
module snn_config_loader #(
    parameter int WEIGHT_BYTES = 144,
    parameter int DELAY_BYTES  = 72
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic [7:0]                cfg_byte,
    output logic                      cfg_ready,
    input  logic                      enable,
    output logic [8*WEIGHT_BYTES-1:0] weights,
    output logic [8*DELAY_BYTES-1:0]  delays,
    output logic [7:0]                threshold,
    output logic [7:0]                decay,
    output logic [7:0]                refractory_period,
    output logic                      cfg_done,
    output logic                      cfg_error,
    output logic                      net_enable
);

    localparam int N = WEIGHT_BYTES + DELAY_BYTES + 3;
    localparam logic [8:0] LAST_IDX       = 9'(N - 1);
    localparam logic [8:0] THRESHOLD_IDX  = 9'(N - 3);
    localparam logic [8:0] DECAY_IDX      = 9'(N - 2);
    localparam logic [8:0] REFRACTORY_IDX = 9'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [8:0] idx_reg;
    logic       accept;
    logic       load_accept;

    // A start request always wins over a byte offered in the same cycle.
    assign accept      = cfg_valid && cfg_ready && !cfg_start;
    assign load_accept = accept && (state_reg == LOAD);

`ifdef SNN_CFG_CHECKSUM_EN
    logic [7:0] sum_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg <= 8'h00;
        end else if (cfg_start) begin
            sum_reg <= 8'h00;
        end else if (load_accept) begin
            sum_reg <= sum_reg + cfg_byte;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cfg_start) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_accept && (idx_reg == LAST_IDX)) begin
`ifdef SNN_CFG_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end
                end
                CHECK: begin
`ifdef SNN_CFG_CHECKSUM_EN
                    if (accept) begin
                        state_next = (cfg_byte == sum_reg) ? DONE : ERROR;
                    end
`endif
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state_reg == LOAD) || (state_reg == CHECK);
        cfg_done  = (state_reg == DONE);
`ifdef SNN_CFG_CHECKSUM_EN
        cfg_error = (state_reg == ERROR);
`else
        cfg_error = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg <= 9'd0;
        end else if (cfg_start) begin
            idx_reg <= 9'd0;
        end else if (accept) begin
            idx_reg <= idx_reg + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            net_enable <= 1'b0;
        end else begin
            net_enable <= enable && cfg_done;
        end
    end

    // One register per byte lane, each decoding its own stream position.
    for (genvar gi = 0; gi < WEIGHT_BYTES; gi++) begin : g_weight
        logic [7:0] byte_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                byte_reg <= 8'h00;
            end else if (load_accept && (idx_reg == 9'(gi))) begin
                byte_reg <= cfg_byte;
            end
        end
        assign weights[gi*8 +: 8] = byte_reg;
    end

    for (genvar gi = 0; gi < DELAY_BYTES; gi++) begin : g_delay
        logic [7:0] byte_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                byte_reg <= 8'h00;
            end else if (load_accept && (idx_reg == 9'(WEIGHT_BYTES + gi))) begin
                byte_reg <= cfg_byte;
            end
        end
        assign delays[gi*8 +: 8] = byte_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            threshold         <= 8'h00;
            decay             <= 8'h00;
            refractory_period <= 8'h00;
        end else if (load_accept) begin
            if (idx_reg == THRESHOLD_IDX) begin
                threshold <= cfg_byte;
            end
            if (idx_reg == DECAY_IDX) begin
                decay <= cfg_byte;
            end
            if (idx_reg == REFRACTORY_IDX) begin
                refractory_period <= cfg_byte;
            end
        end
    end

endmodule
